sd_cmd_sequencer: RTL and testbench
===================================

// Module: sd_cmd_sequencer
// PURPOSE
//  Host-side sequencer for the SD CMD line. Takes one command request from the register block,
//  builds the 48-bit frame (start, tx bit, index, argument, CRC7, end), drives the CMD
//  parallel-to-serial wrapper, then arms the serial-to-parallel wrapper for the response.
//  Checks the response (timeout, CRC7, index), retries up to a programmed limit and reports
//  done/error back to the registers. Sits between the registers and cmd_phys in sd_host.
// PARAMETERS
//  FRAME_W    48  command/response frame width in bits
//  TIMEOUT_W  16  width of the response timeout counter
//  RETRY_W     2  width of the retry limit and retry counter
// PORTS
//  clock          in   1          system clock; all state on rising edge
//  reset          in   1          asynchronous, active-low; clears all state
//  new_cmd        in   1          request; sampled only in IDLE
//  cmd_index      in   6          command index; captured with new_cmd
//  cmd_arg        in   32         command argument; captured with new_cmd
//  resp_en        in   1          1 = expect 48-bit response, 0 = no response
//  timeout_val    in   TIMEOUT_W  clocks to wait for des_complete after ser_complete
//  max_retry      in   RETRY_W    retries allowed after a timeout or CRC error
//  ser_enable     out  1          enable to CMD parallel-to-serial wrapper
//  ser_load_send  out  1          load/send strobe to serializer, 1 clock
//  ser_frame      out  FRAME_W    frame to serialize, bit 47 first
//  ser_complete   in   1          serializer finished shifting the frame
//  des_enable     out  1          enable to CMD serial-to-parallel wrapper
//  des_complete   in   1          deserializer holds a full response frame
//  des_data       in   FRAME_W    received frame, bit 47 = start bit
//  busy           out  1          high from request acceptance until done
//  done           out  1          1-clock pulse at end of sequence, success or error
//  resp_arg       out  32         des_data[39:8] of last accepted response
//  err_timeout    out  1          sticky until next accepted request
//  err_crc        out  1          sticky until next accepted request
//  err_index      out  1          sticky until next accepted request
// BEHAVIOUR
//  Reset: state IDLE; every output 0; internal frame, CRC, counters 0. Asserting reset mid-sequence
//   drops enables the same instant (async); no done pulse is issued.
//  IDLE: new_cmd=1 -> capture index/arg/resp_en, clear err_*, retry_cnt=0, busy=1, go CRC_TX.
//   new_cmd while busy is ignored; no queueing.
//  CRC_TX: serial CRC7 (x^7+x^3+1, init 0) over {2'b01,index,arg}, MSB first, 1 bit/clock, 40 clocks.
//   ser_frame = {2'b01,index,arg,crc7,1'b1}; registered, stable until the next request.
//  LOAD: ser_enable=1, ser_load_send=1 for exactly 1 clock, then SEND.
//  SEND: ser_enable held 1 until ser_complete. Then ser_enable=0. If resp_en=0 go DONE.
//   Otherwise load tmo_cnt=timeout_val, des_enable=1, go WAIT_RESP.
//  WAIT_RESP: tmo_cnt decrements each clock. des_complete -> latch des_data, des_enable=0, go CRC_RX.
//   If des_complete and tmo_cnt==0 occur on the same clock, des_complete wins.
//   tmo_cnt==0 without des_complete -> des_enable=0, set err_timeout, go RETRY.
//   timeout_val=0 -> timeout on the first WAIT_RESP clock unless des_complete is present then.
//  CRC_RX: same CRC engine over latched bits [47:8], 40 clocks. Mismatch with [7:1] -> err_crc, RETRY.
//   CRC ok: resp_arg=[39:8]; err_index=1 if [45:40]!=captured index; go DONE. No retry on index error.
//  RETRY: retry_cnt<max_retry -> retry_cnt++, clear err_timeout/err_crc, go LOAD; the frame is reused,
//   so the CRC is not recomputed. Otherwise go DONE with the error kept.
//  DONE: done=1 for 1 clock, busy=0, go IDLE. A new_cmd on the clock after done is accepted.
//  Start bit (47) or end bit (0) wrong in the response counts as a CRC error.
//  Latency, resp_en=0: request to first ser_load_send = 41 clocks. Done follows ser_complete by 1 clock.
//  Latency, response ok: des_complete to done = 42 clocks.
// TESTING
//  1 CMD0 arg 0, resp_en=0 -> ser_frame=48'h40_0000_0000_95; 1 load pulse; done 1 clk after ser_complete; no err.
//  2 CMD8 arg 0x1AA, response 48'h08_0000_01AA_13 -> crc7 0x09; resp_arg=0x1AA; no err.
//  3 CMD17 arg 0, timeout_val=20, max_retry=2, no des_complete -> 3 load pulses; err_timeout=1; one done.
//  4 response with a flipped CRC bit, max_retry=1, second response good -> 2 loads; err_crc=0 at done.
//  5 good-CRC response with index 6'd5 for CMD7 -> err_index=1, err_crc=0, resp_arg latched, no retry.
//  6 reset low during WAIT_RESP, then new_cmd while busy -> outputs 0 at once; extra new_cmd ignored.

Source files
------------

// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line sequencer: builds the 48-bit command frame, drives the serializer,
// collects and checks the response, retries on timeout/CRC error and reports status.
module sd_cmd_sequencer #(
   parameter int FRAME_W   = 48,
   parameter int TIMEOUT_W = 16,
   parameter int RETRY_W   = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 new_cmd,
   input  logic [5:0]           cmd_index,
   input  logic [31:0]          cmd_arg,
   input  logic                 resp_en,
   input  logic [TIMEOUT_W-1:0] timeout_val,
   input  logic [RETRY_W-1:0]   max_retry,
   output logic                 ser_enable,
   output logic                 ser_load_send,
   output logic [FRAME_W-1:0]   ser_frame,
   input  logic                 ser_complete,
   output logic                 des_enable,
   input  logic                 des_complete,
   input  logic [FRAME_W-1:0]   des_data,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          resp_arg,
   output logic                 err_timeout,
   output logic                 err_crc,
   output logic                 err_index
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CRC_TX = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_SEND   = 3'd3;
   localparam logic [2:0] ST_WAIT   = 3'd4;
   localparam logic [2:0] ST_CRC_RX = 3'd5;
   localparam logic [2:0] ST_RETRY  = 3'd6;
   localparam logic [2:0] ST_DONE   = 3'd7;

   localparam logic [RETRY_W-1:0]   RETRY_ONE = RETRY_W'(1'b1);
   localparam logic [TIMEOUT_W-1:0] TMO_ONE   = TIMEOUT_W'(1'b1);
   localparam logic [TIMEOUT_W-1:0] TMO_ZERO  = TIMEOUT_W'(1'b0);

   // One serial step of CRC7 (x^7 + x^3 + 1), message bit shifted in MSB first.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      logic fb;
      fb = din ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   logic [2:0]           state_q, state_d;
   logic [5:0]           idx_q, idx_d;
   logic [31:0]          arg_q, arg_d;
   logic                 resp_en_q, resp_en_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
   logic [5:0]           cnt_q, cnt_d;
   logic [6:0]           crc_q, crc_d;
   logic [39:0]          msg_q, msg_d;
   logic                 rx_start_q, rx_start_d;
   logic [45:0]          rx_body_q, rx_body_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic [31:0]          resp_arg_q, resp_arg_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 err_crc_q, err_crc_d;
   logic                 err_index_q, err_index_d;
   logic                 ser_enable_q, ser_enable_d;
   logic                 ser_load_send_q, ser_load_send_d;
   logic                 des_enable_q, des_enable_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [6:0]           crc_next_s;
   logic                 rx_bad_s;

   // Next-state, datapath and registered-output decode for the whole sequence.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      arg_d         = arg_q;
      resp_en_d     = resp_en_q;
      retry_d       = retry_q;
      tmo_d         = tmo_q;
      cnt_d         = cnt_q;
      crc_d         = crc_q;
      msg_d         = msg_q;
      rx_start_d    = rx_start_q;
      rx_body_d     = rx_body_q;
      frame_d       = frame_q;
      resp_arg_d    = resp_arg_q;
      err_timeout_d = err_timeout_q;
      err_crc_d     = err_crc_q;
      err_index_d   = err_index_q;
      crc_next_s    = crc7_step(crc_q, msg_q[39]);
      // A wrong start or end bit is folded into the CRC error.
      rx_bad_s      = (crc_q != rx_body_q[7:1]) || rx_start_q || !rx_body_q[0];

      case (state_q)
         ST_IDLE: begin
            if (new_cmd) begin
               idx_d         = cmd_index;
               arg_d         = cmd_arg;
               resp_en_d     = resp_en;
               retry_d       = '0;
               err_timeout_d = 1'b0;
               err_crc_d     = 1'b0;
               err_index_d   = 1'b0;
               cnt_d         = 6'd0;
               crc_d         = 7'd0;
               msg_d         = {2'b01, cmd_index, cmd_arg};
               state_d       = ST_CRC_TX;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CRC_TX: begin
            crc_d = crc_next_s;
            msg_d = {msg_q[38:0], 1'b0};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd39) begin
               frame_d = {2'b01, idx_q, arg_q, crc_next_s, 1'b1};
               state_d = ST_LOAD;
            end else begin
               state_d = ST_CRC_TX;
            end
         end
         ST_LOAD: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (ser_complete) begin
               if (resp_en_q) begin
                  tmo_d   = timeout_val;
                  state_d = ST_WAIT;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_WAIT: begin
            // A response arriving on the expiry clock still counts.
            if (des_complete) begin
               rx_start_d = des_data[47];
               rx_body_d  = des_data[45:0];
               msg_d      = des_data[47:8];
               crc_d      = 7'd0;
               cnt_d      = 6'd0;
               state_d    = ST_CRC_RX;
            end else if (tmo_q == TMO_ZERO) begin
               err_timeout_d = 1'b1;
               state_d       = ST_RETRY;
            end else begin
               tmo_d = tmo_q - TMO_ONE;
            end
         end
         ST_CRC_RX: begin
            if (cnt_q == 6'd40) begin
               if (rx_bad_s) begin
                  err_crc_d = 1'b1;
                  state_d   = ST_RETRY;
               end else begin
                  resp_arg_d  = rx_body_q[39:8];
                  err_index_d = (rx_body_q[45:40] != idx_q);
                  state_d     = ST_DONE;
               end
            end else begin
               crc_d = crc_next_s;
               msg_d = {msg_q[38:0], 1'b0};
               cnt_d = cnt_q + 6'd1;
            end
         end
         ST_RETRY: begin
            // The frame register still holds the command, so resend it as is.
            if (retry_q < max_retry) begin
               retry_d       = retry_q + RETRY_ONE;
               err_timeout_d = 1'b0;
               err_crc_d     = 1'b0;
               state_d       = ST_LOAD;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ser_enable_d    = (state_d == ST_LOAD) || (state_d == ST_SEND);
      ser_load_send_d = (state_d == ST_LOAD);
      des_enable_d    = (state_d == ST_WAIT);
      done_d          = (state_d == ST_DONE);
      busy_d          = (state_d != ST_IDLE) && (state_d != ST_DONE);
   end

   // State and output registers; reset drops every enable immediately.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         idx_q           <= 6'd0;
         arg_q           <= 32'd0;
         resp_en_q       <= 1'b0;
         retry_q         <= '0;
         tmo_q           <= '0;
         cnt_q           <= 6'd0;
         crc_q           <= 7'd0;
         msg_q           <= 40'd0;
         rx_start_q      <= 1'b0;
         rx_body_q       <= 46'd0;
         frame_q         <= '0;
         resp_arg_q      <= 32'd0;
         err_timeout_q   <= 1'b0;
         err_crc_q       <= 1'b0;
         err_index_q     <= 1'b0;
         ser_enable_q    <= 1'b0;
         ser_load_send_q <= 1'b0;
         des_enable_q    <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         arg_q           <= arg_d;
         resp_en_q       <= resp_en_d;
         retry_q         <= retry_d;
         tmo_q           <= tmo_d;
         cnt_q           <= cnt_d;
         crc_q           <= crc_d;
         msg_q           <= msg_d;
         rx_start_q      <= rx_start_d;
         rx_body_q       <= rx_body_d;
         frame_q         <= frame_d;
         resp_arg_q      <= resp_arg_d;
         err_timeout_q   <= err_timeout_d;
         err_crc_q       <= err_crc_d;
         err_index_q     <= err_index_d;
         ser_enable_q    <= ser_enable_d;
         ser_load_send_q <= ser_load_send_d;
         des_enable_q    <= des_enable_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
      end
   end

   assign ser_enable    = ser_enable_q;
   assign ser_load_send = ser_load_send_q;
   assign ser_frame     = frame_q;
   assign des_enable    = des_enable_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign resp_arg      = resp_arg_q;
   assign err_timeout   = err_timeout_q;
   assign err_crc       = err_crc_q;
   assign err_index     = err_index_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Scoreboard bench for sd_cmd_sequencer: driver pushes expectations computed from a
// polynomial-division CRC model; a negedge monitor pops and compares on each done.
module tb_sd_cmd_sequencer;

   logic        clock, reset;
   logic        new_cmd, resp_en, ser_complete, des_complete;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic [15:0] timeout_val;
   logic [1:0]  max_retry;
   logic [47:0] des_data;
   logic        ser_enable, ser_load_send, des_enable, busy, done;
   logic        err_timeout, err_crc, err_index;
   logic [47:0] ser_frame;
   logic [31:0] resp_arg;

   sd_cmd_sequencer dut (
      .clock(clock), .reset(reset), .new_cmd(new_cmd), .cmd_index(cmd_index),
      .cmd_arg(cmd_arg), .resp_en(resp_en), .timeout_val(timeout_val),
      .max_retry(max_retry), .ser_enable(ser_enable), .ser_load_send(ser_load_send),
      .ser_frame(ser_frame), .ser_complete(ser_complete), .des_enable(des_enable),
      .des_complete(des_complete), .des_data(des_data), .busy(busy), .done(done),
      .resp_arg(resp_arg), .err_timeout(err_timeout), .err_crc(err_crc),
      .err_index(err_index)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [47:0] frame;
      bit          ren;
      int          loads;
      bit          et, ec, ei, good;
      logic [31:0] rarg;
   } exp_t;

   typedef struct {
      bit          timeout;
      int          delay;
      logic [47:0] frame;
   } att_t;

   exp_t        exp_q[$];
   att_t        att_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model_resp_arg = 32'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input string act, input string req);
      n_tests++;
      n_fail++;
      $display("FAIL %s: actual=%s required=%s", name, act, req);
   endtask

   // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1.
   function automatic logic [6:0] crc7_ref(input logic [39:0] m);
      logic [46:0] v;
      v = {m, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
      return v[6:0];
   endfunction

   function automatic logic [11:0] mk(input int k0, input int k1, input int k2, input int k3);
      return {3'(k3), 3'(k2), 3'(k1), 3'(k0)};
   endfunction

   // kinds per attempt: 0 good, 1 no response, 2 crc bit flip, 3 start flip, 4 end flip
   task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input bit ren,
                        input int tmo, input int mr, input logic [11:0] kv,
                        input logic [5:0] ridx, input logic [31:0] rarg, input bit late);
      exp_t        e;
      att_t        a;
      int          kind, b;
      logic [47:0] f;
      e.frame = {2'b01, idx, arg, crc7_ref({2'b01, idx, arg}), 1'b1};
      e.ren = ren; e.loads = 1; e.et = 0; e.ec = 0; e.ei = 0; e.good = 0;
      if (ren) begin
         for (int k = 0; k <= mr; k++) begin
            kind    = int'(kv[3*k +: 3]);
            e.loads = k + 1;
            f = {2'b00, ridx, rarg, crc7_ref({2'b00, ridx, rarg}), 1'b1};
            if (kind == 2) begin b = int'($urandom_range(1, 7)); f[b] = ~f[b]; end
            if (kind == 3) f[47] = ~f[47];
            if (kind == 4) f[0] = ~f[0];
            a.timeout = (kind == 1);
            a.delay   = late ? tmo : int'($urandom_range(0, tmo));
            a.frame   = f;
            att_q.push_back(a);
            if (kind == 0) begin
               e.et = 0; e.ec = 0; e.ei = (ridx != idx); e.good = 1;
               model_resp_arg = rarg;
               break;
            end else if (kind == 1) begin
               e.et = 1; e.ec = 0;
            end else begin
               e.et = 0; e.ec = 1;
            end
         end
      end
      e.rarg = model_resp_arg;
      exp_q.push_back(e);
      #1;
      cmd_index = idx; cmd_arg = arg; resp_en = ren;
      timeout_val = 16'(tmo); max_retry = 2'(mr); new_cmd = 1'b1;
      @(posedge clock); #1;
      new_cmd = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom; resp_en = 1'($urandom);
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail_now("wait_done", "no done", "done");
         exp_q.delete();
         att_q.delete();
      end
   endtask

   // Serializer and deserializer stand-ins.
   initial begin
      int   ser_cnt = 0;
      int   rsp_cnt = -1;
      bit   des_act = 0;
      att_t a;
      forever begin
         @(posedge clock); #1;
         ser_complete = 1'b0;
         des_complete = 1'b0;
         if (!reset) begin
            ser_cnt = 0; rsp_cnt = -1; des_act = 0;
         end else begin
            if (ser_cnt > 0) begin
               ser_cnt--;
               if (ser_cnt == 0) ser_complete = 1'b1;
            end
            if (ser_load_send) ser_cnt = int'($urandom_range(1, 4));
            if (!des_enable) begin
               des_act = 0; rsp_cnt = -1;
            end else if (!des_act) begin
               des_act = 1; rsp_cnt = -1;
               if (att_q.size() != 0) begin
                  a = att_q.pop_front();
                  if (!a.timeout) rsp_cnt = a.delay;
               end
            end
            if (rsp_cnt == 0) begin
               des_complete = 1'b1; des_data = a.frame; rsp_cnt = -1;
            end else if (rsp_cnt > 0) begin
               rsp_cnt--;
            end
         end
      end
   end

   // Monitor: checks frames and latency at each load, pops the scoreboard at each done.
   initial begin
      int   ncyc = 0, req_n = 0, ser_n = 0, des_n = 0, loads = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            loads = 0;
         end else begin
            ncyc++;
            if (new_cmd && !busy && !done) begin req_n = ncyc; loads = 0; end
            if (ser_load_send) begin
               loads++;
               chk("load_busy", 64'(busy), 64'd1);
               if (exp_q.size() != 0) chk("frame", 64'(ser_frame), 64'(exp_q[0].frame));
               else fail_now("load_unexpected", "load", "idle");
               if (loads == 1) chk("load_latency", 64'(ncyc - req_n), 64'd41);
            end
            if (ser_complete) ser_n = ncyc;
            if (des_complete && des_enable) des_n = ncyc;
            if (done) begin
               if (exp_q.size() == 0) begin
                  fail_now("done_unexpected", "done", "no done");
               end else begin
                  e = exp_q.pop_front();
                  chk("done_busy", 64'(busy), 64'd0);
                  chk("loads", 64'(loads), 64'(e.loads));
                  chk("err_timeout", 64'(err_timeout), 64'(e.et));
                  chk("err_crc", 64'(err_crc), 64'(e.ec));
                  chk("err_index", 64'(err_index), 64'(e.ei));
                  chk("resp_arg", 64'(resp_arg), 64'(e.rarg));
                  if (!e.ren) chk("done_after_ser", 64'(ncyc - ser_n), 64'd1);
                  else if (e.good) chk("done_after_des", 64'(ncyc - des_n), 64'd42);
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0]  idx, ridx;
      logic [31:0] arg;
      logic [11:0] kv;
      int          r;
      reset = 1'b0; new_cmd = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; resp_en = 1'b0;
      timeout_val = 16'd0; max_retry = 2'd0; ser_complete = 1'b0; des_complete = 1'b0;
      des_data = 48'd0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ser_enable", 64'(ser_enable), 64'd0);
      chk("rst_load", 64'(ser_load_send), 64'd0);
      chk("rst_frame", 64'(ser_frame), 64'd0);
      chk("rst_busy_done", 64'({busy, done, des_enable}), 64'd0);
      chk("rst_errs_arg", 64'({err_timeout, err_crc, err_index, resp_arg}), 64'd0);
      @(negedge clock); reset = 1'b1;
      @(posedge clock);

      issue(6'd0, 32'd0, 1'b0, 10, 0, mk(0, 0, 0, 0), 6'd0, 32'd0, 1'b0);
      wait_done();
      @(negedge clock);
      chk("cmd0_frame", 64'(ser_frame), 64'h40_0000_0000_95);
      @(posedge clock);
      issue(6'd8, 32'h1AA, 1'b1, 20, 0, mk(0, 0, 0, 0), 6'd8, 32'h1AA, 1'b0);
      wait_done();
      issue(6'd17, 32'd0, 1'b1, 20, 2, mk(1, 1, 1, 0), 6'd17, 32'd0, 1'b0);
      wait_done();
      issue(6'd17, 32'h1234, 1'b1, 12, 1, mk(2, 0, 0, 0), 6'd17, 32'hCAFE_0001, 1'b0);
      wait_done();
      issue(6'd7, 32'hABCD_0000, 1'b1, 15, 0, mk(0, 0, 0, 0), 6'd5, 32'h0BAD_F00D, 1'b0);
      wait_done();
      issue(6'd2, 32'h55, 1'b1, 0, 0, mk(0, 0, 0, 0), 6'd2, 32'h7777_0000, 1'b1);
      wait_done();
      issue(6'd3, 32'h66, 1'b1, 0, 1, mk(1, 4, 0, 0), 6'd3, 32'h1111_2222, 1'b0);
      wait_done();
      issue(6'd9, 32'h77, 1'b1, 9, 3, mk(3, 4, 2, 0), 6'd9, 32'h3333_4444, 1'b1);
      wait_done();

      for (int t = 0; t < 40; t++) begin
         idx = 6'($urandom); arg = $urandom;
         kv = 12'd0;
         for (int k = 0; k < 4; k++) begin
            r = int'($urandom_range(0, 9));
            kv[3*k +: 3] = (r < 5) ? 3'd0 : (r < 7) ? 3'd1 : 3'(r - 5);
         end
         ridx = ($urandom_range(0, 1) == 0) ? idx : 6'($urandom);
         issue(idx, arg, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 25)),
               int'($urandom_range(0, 3)), kv, ridx, $urandom, ($urandom_range(0, 3) == 0));
         wait_done();
         repeat ($urandom_range(0, 2)) @(posedge clock);
      end

      issue(6'd17, 32'h99, 1'b1, 30, 0, mk(1, 0, 0, 0), 6'd17, 32'd0, 1'b0);
      r = 0;
      while (!des_enable && r < 200) begin @(negedge clock); r++; end
      if (!des_enable) fail_now("reach_wait", "no des_enable", "des_enable");
      #2 reset = 1'b0;
      #1;
      chk("async_enables", 64'({ser_enable, ser_load_send, des_enable}), 64'd0);
      chk("async_busy_done", 64'({busy, done}), 64'd0);
      chk("async_frame", 64'(ser_frame), 64'd0);
      chk("async_errs_arg", 64'({err_timeout, err_crc, err_index, resp_arg}), 64'd0);
      exp_q.delete(); att_q.delete(); model_resp_arg = 32'd0;
      repeat (3) @(posedge clock);
      @(negedge clock); #2 reset = 1'b1;
      @(posedge clock);
      issue(6'd9, 32'h0F0F_0F0F, 1'b1, 20, 0, mk(0, 0, 0, 0), 6'd9, 32'h2468_ACE0, 1'b0);
      repeat (3) @(posedge clock);
      #1 new_cmd = 1'b1; cmd_index = 6'd33; cmd_arg = 32'hDEAD_BEEF; resp_en = 1'b0;
      @(posedge clock); #1 new_cmd = 1'b0;
      wait_done();
      repeat (60) @(posedge clock);
      @(negedge clock);
      chk("idle_after_ignored_cmd", 64'({busy, ser_enable, des_enable}), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
